// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch -- GeMIPS instruction-fetch stage.
//
// Generates the program counter, issues one-word fetch requests to the
// instruction SRAM and presents each returned word, with its PC, to the
// IF/ID register. Fetching freezes while if_stop is high; branch/jump
// redirects from ID are taken at the next request boundary, since a request
// already started is always allowed to complete.
//
// Parameters:
//   RESET_PC       first fetch address after reset
//
// Ports:
//   clk            clock, rising-edge active
//   rst            asynchronous, active-high reset
//   if_stop        1 = stall fetch, 0 = run
//   branch_flag    one-cycle redirect pulse from ID
//   branch_target  redirect address, sampled with branch_flag
//   inst_req       fetch request to instruction SRAM
//   inst_addr      fetch address, stable while inst_req is high
//   inst_ack       SRAM completed the current request
//   inst_rdata     fetched word, valid with inst_ack
//   if_pc          PC of the word on if_inst
//   if_inst        fetched instruction to IF/ID
//   if_valid       if_inst/if_pc hold a real instruction
//   if_adel        sticky misaligned-redirect flag (IF_ALIGN_CHECK_EN only)
//
// Build option:
//   IF_ALIGN_CHECK_EN  when defined, misaligned redirect targets raise if_adel
//                      and halt fetch; otherwise target bits [1:0] are cleared.
// ----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stop,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        if_adel
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;
    logic        pend_vld_q;
    logic [31:0] pend_tgt_q;
    logic        adel_q;

    // Redirect that applies at the current commit point: a same-cycle pulse
    // takes priority over (and supersedes) an older pending one.
    logic        redir_vld;
    logic [31:0] redir_raw;
    logic [31:0] redir_tgt;
    logic        redir_bad;

    always_comb begin
        redir_vld = branch_flag | pend_vld_q;
        redir_raw = branch_flag ? branch_target : pend_tgt_q;
`ifdef IF_ALIGN_CHECK_EN
        redir_tgt = redir_raw;
        redir_bad = redir_vld && (redir_raw[1:0] != 2'b00);
`else
        redir_tgt = redir_raw & 32'hFFFF_FFFC;
        redir_bad = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0;
            valid_q    <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0;
            adel_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Late acks from a request cut off by reset land here and
                    // are ignored.
                    state_q <= if_stop ? S_STALL : S_REQ;
                    req_q   <= ~if_stop;
                    if (branch_flag) begin
                        pend_vld_q <= 1'b1;
                        pend_tgt_q <= branch_target;
                    end
                end

                S_REQ: begin
                    if (inst_ack) begin
                        pend_vld_q <= 1'b0;
                        if (redir_bad) begin
                            // Misaligned target: report it in place of a
                            // fetched word and park until a good redirect.
                            pc_q    <= redir_raw;
                            inst_q  <= 32'h0;
                            valid_q <= 1'b1;
                            adel_q  <= 1'b1;
                            state_q <= S_STALL;
                            req_q   <= 1'b0;
                        end else begin
                            pc_q <= addr_q;
                            if (redir_vld) begin
                                // Word belongs to the wrong path; drop it.
                                inst_q  <= 32'h0;
                                valid_q <= 1'b0;
                                addr_q  <= redir_tgt;
                                adel_q  <= 1'b0;
                            end else begin
                                inst_q  <= inst_rdata;
                                valid_q <= 1'b1;
                                addr_q  <= addr_q + 32'd4;
                            end
                            state_q <= if_stop ? S_STALL : S_REQ;
                            req_q   <= ~if_stop;
                        end
                    end else if (branch_flag) begin
                        pend_vld_q <= 1'b1;
                        pend_tgt_q <= branch_target;
                    end
                end

                S_STALL: begin
                    if (!if_stop) begin
                        if (redir_bad) begin
                            pend_vld_q <= 1'b0;
                            pc_q       <= redir_raw;
                            inst_q     <= 32'h0;
                            valid_q    <= 1'b1;
                            adel_q     <= 1'b1;
                        end else if (redir_vld) begin
                            pend_vld_q <= 1'b0;
                            addr_q     <= redir_tgt;
                            adel_q     <= 1'b0;
                            state_q    <= S_REQ;
                            req_q      <= 1'b1;
                        end else if (!adel_q) begin
                            // adel_q parks fetch until a redirect arrives.
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end
                    end else if (branch_flag) begin
                        pend_vld_q <= 1'b1;
                        pend_tgt_q <= branch_target;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign inst_req  = req_q;
    assign inst_addr = addr_q;
    assign if_pc     = pc_q;
    assign if_inst   = inst_q;
    assign if_valid  = valid_q;
`ifdef IF_ALIGN_CHECK_EN
    assign if_adel   = adel_q;
`endif

endmodule
